// File: rtl/load_store_unit_if.sv
// load_store_unit_if: execute-stage request, DataMemory port and completion signals of the load/store unit.
interface load_store_unit_if;
    logic        valid;
    logic        loadReq;
    logic        storeReq;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] storeData;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memReadData;
    logic [31:0] loadData;
    logic        busy;
    logic        done;
    logic        error;

    modport slave (
        input  valid, loadReq, storeReq, funct3, address, storeData, memReadData,
        output memAddress, memWriteData, memRead, memWrite, loadData, busy, done, error
    );
    modport master (
        output valid, loadReq, storeReq, funct3, address, storeData, memReadData,
        input  memAddress, memWriteData, memRead, memWrite, loadData, busy, done, error
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores against a word-wide DataMemory, sub-word stores by read-modify-write.
module load_store_unit #(
    parameter int MEM_WORDS = 32
) (
    input logic              clock,
    input logic              reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_t;
    state_t      state, state_n;
    logic [31:0] addr_q, wdata_q, shifted, rd_ext, mask, merged;
    logic [2:0]  f3_q;
    logic [4:0]  sh;
    logic        err_q, accept, bad;

    always_comb begin
        accept  = state == IDLE && bus.valid && (bus.loadReq || bus.storeReq);
        bad     = (bus.loadReq && bus.storeReq)
                || bus.funct3 == 3'b011
                || (bus.loadReq ? bus.funct3[2:1] == 2'b11 : bus.funct3[2])
                || (bus.funct3[1:0] == 2'b01 && bus.address[0])
                || (bus.funct3 == 3'b010 && bus.address[1:0] != 2'b00)
                || {2'b00, bus.address[31:2]} >= 32'(MEM_WORDS);
        sh      = {addr_q[1:0], 3'b000};
        shifted = bus.memReadData >> sh;
        rd_ext  = f3_q[1] ? bus.memReadData
                : f3_q[0] ? {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]}
                :           {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
        mask    = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        merged  = (bus.memReadData & ~mask) | ((wdata_q << sh) & mask);
    end

    always_ff @(posedge clock)
        state <= reset ? IDLE : state_n;

    always_comb begin
        state_n          = state;
        bus.memRead      = 1'b0;
        bus.memWrite     = 1'b0;
        bus.memAddress   = 32'h0;
        bus.memWriteData = wdata_q;
        case (state)
            IDLE:    if (accept) state_n = bad ? DONE : bus.loadReq ? LOAD : bus.funct3[1] ? WRITE : RMW_RD;
            LOAD:    begin bus.memRead = 1'b1; bus.memAddress = {2'b00, addr_q[31:2]}; state_n = DONE; end
            RMW_RD:  begin bus.memRead = 1'b1; bus.memAddress = {2'b00, addr_q[31:2]}; state_n = WRITE; end
            WRITE:   begin bus.memWrite = !reset; bus.memAddress = {2'b00, addr_q[31:2]}; state_n = DONE; end
            default: state_n = IDLE;
        endcase
        bus.busy  = state != IDLE;
        bus.done  = state == DONE;
        bus.error = state == DONE && err_q;
    end

    // word stores write the latched operand directly; sub-word stores overwrite it with the merged word
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.loadData <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= bus.address;
                f3_q    <= bus.funct3;
                wdata_q <= bus.storeData;
                err_q   <= bad;
            end
            if (state == LOAD) bus.loadData <= rd_ext;
            if (state == RMW_RD) wdata_q <= merged;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a behavioural 32-word DataMemory.
module tb_load_store_unit;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    load_store_unit_if lsu();
    load_store_unit #(.MEM_WORDS(32)) dut (.clock(clock), .reset(reset), .bus(lsu.slave));

    logic [31:0] mem [32];
    logic        pl_en;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;

    assign lsu.memReadData = (lsu.memAddress < 32) ? mem[lsu.memAddress[4:0]] : 32'h0;
    always @(posedge clock)
        if (lsu.memWrite) mem[lsu.memAddress[4:0]] <= lsu.memWriteData;
        else if (pl_en) mem[pl_addr] <= pl_data;

    typedef struct {
        logic        err;
        logic [31:0] ld;
        int          lat;
        int          rd;
        int          wr;
    } exp_t;
    exp_t        sb[$];
    int          checks = 0, fails = 0;
    logic [31:0] last_ld = 32'h0;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lane, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic poke(input int i, input logic [31:0] d);
        @(negedge clock);
        pl_en = 1'b1; pl_addr = 5'(i); pl_data = d;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        lsu.valid = 1'b1; lsu.loadReq = ld; lsu.storeReq = st;
        lsu.funct3 = f3; lsu.address = a; lsu.storeData = d;
        @(negedge clock);
        lsu.valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int rd, output int wr, output bit both);
        lat = 0; rd = 0; wr = 0; both = 0;
        while (!lsu.done && lat < 10) begin
            rd += int'(lsu.memRead);
            wr += int'(lsu.memWrite);
            both |= lsu.memRead & lsu.memWrite;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({lsu.busy, lsu.done, lsu.error, lsu.memRead, lsu.memWrite} !== 5'b0) begin
            fails++; $display("FAIL reset_flags got %b required 00000", {lsu.busy, lsu.done, lsu.error, lsu.memRead, lsu.memWrite});
        end
        checks++;
        if (lsu.loadData !== 32'h0 || lsu.memAddress !== 32'h0) begin
            fails++; $display("FAIL reset_data loadData=%h memAddress=%h required 0", lsu.loadData, lsu.memAddress);
        end
        reset = 1'b0;
    endtask

    task automatic test_load;
        logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
        logic [31:0] as  [6] = '{32'h0C, 32'h0F, 32'h0E, 32'h0C, 32'h0C, 32'h0D};
        logic [31:0] exs [6] = '{32'hFFFFFFA5, 32'h00000084, 32'hFFFF8421, 32'h0000F0A5, 32'h8421F0A5, 32'hFFFFFFF0};
        int lat, rd, wr; bit both; exp_t e;
        logic [2:0] f3; logic [31:0] a, w; int idx;
        poke(3, 32'h8421F0A5);
        for (int i = 0; i < 14; i++) begin
            if (i < 6) begin
                f3 = f3s[i]; a = as[i]; w = exs[i];
            end else begin
                idx = $urandom_range(31, 5);
                w = $urandom;
                poke(idx, w);
                case ($urandom_range(4, 0))
                    0: f3 = 3'b000; 1: f3 = 3'b100; 2: f3 = 3'b001; 3: f3 = 3'b101; default: f3 = 3'b010;
                endcase
                a = {idx[29:0], 2'b00};
                if (f3 != 3'b010) a[1] = 1'($urandom);
                if (f3[1:0] == 2'b00) a[0] = 1'($urandom);
                w = ref_load(f3, a[1:0], w);
            end
            sb.push_back('{err: 1'b0, ld: w, lat: 1, rd: 1, wr: 0});
            issue(1'b1, 1'b0, f3, a, 32'h0);
            wait_done(lat, rd, wr, both);
            e = sb.pop_front();
            last_ld = e.ld;
            checks++;
            if ({lsu.error, lsu.loadData} !== {e.err, e.ld}) begin
                fails++; $display("FAIL load_%0d f3=%b a=%h got err=%b data=%h required err=%b data=%h", i, f3, a, lsu.error, lsu.loadData, e.err, e.ld);
            end
            checks++;
            if (lat != e.lat || rd != e.rd || wr != e.wr || both) begin
                fails++; $display("FAIL load_timing_%0d got lat=%0d rd=%0d wr=%0d both=%b required lat=%0d rd=%0d wr=%0d", i, lat, rd, wr, both, e.lat, e.rd, e.wr);
            end
        end
    endtask

    task automatic test_store;
        logic [2:0]  f3s [3] = '{3'b000, 3'b001, 3'b010};
        logic [31:0] as  [3] = '{32'h09, 32'h0A, 32'h10};
        logic [31:0] ds  [3] = '{32'h123456AB, 32'h9999BEEF, 32'hDEADBEEF};
        int          wi  [3] = '{2, 2, 4};
        logic [31:0] wx  [3] = '{32'h1122AB44, 32'hBEEFAB44, 32'hDEADBEEF};
        int lat, rd, wr; bit both; exp_t e;
        poke(2, 32'h11223344);
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{err: 1'b0, ld: last_ld, lat: (i == 2) ? 1 : 2, rd: (i == 2) ? 0 : 1, wr: 1});
            issue(1'b0, 1'b1, f3s[i], as[i], ds[i]);
            wait_done(lat, rd, wr, both);
            e = sb.pop_front();
            checks++;
            if ({lsu.error, lsu.loadData} !== {e.err, e.ld}) begin
                fails++; $display("FAIL store_%0d got err=%b loadData=%h required err=%b loadData=%h", i, lsu.error, lsu.loadData, e.err, e.ld);
            end
            checks++;
            if (lat != e.lat || rd != e.rd || wr != e.wr || both) begin
                fails++; $display("FAIL store_timing_%0d got lat=%0d rd=%0d wr=%0d both=%b required lat=%0d rd=%0d wr=%0d", i, lat, rd, wr, both, e.lat, e.rd, e.wr);
            end
            checks++;
            if (mem[wi[i]] !== wx[i]) begin
                fails++; $display("FAIL store_mem_%0d word %0d got %h required %h", i, wi[i], mem[wi[i]], wx[i]);
            end
        end
        sb.push_back('{err: 1'b0, ld: 32'hDEADBEEF, lat: 1, rd: 1, wr: 0});
        issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        wait_done(lat, rd, wr, both);
        e = sb.pop_front();
        last_ld = e.ld;
        checks++;
        if (lsu.loadData !== e.ld || lat != e.lat) begin
            fails++; $display("FAIL lw_after_sw got %h lat=%0d required %h lat=%0d", lsu.loadData, lat, e.ld, e.lat);
        end
    endtask

    task automatic test_errors;
        logic        lds [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        sts [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3s [7] = '{3'b010, 3'b001, 3'b010, 3'b010, 3'b100, 3'b011, 3'b010};
        logic [31:0] as  [7] = '{32'h06, 32'h03, 32'h80, 32'h10, 32'h04, 32'h04, 32'h7C};
        int lat, rd, wr; bit both; exp_t e;
        logic [31:0] m0, m1;
        poke(1, 32'hCAFEF00D);
        m0 = mem[0]; m1 = mem[1];
        for (int i = 0; i < 7; i++) begin
            sb.push_back('{err: (i != 6), ld: last_ld, lat: (i == 6) ? 1 : 0, rd: 0, wr: (i == 6) ? 1 : 0});
            issue(lds[i], sts[i], f3s[i], as[i], 32'h5A5A5A5A);
            wait_done(lat, rd, wr, both);
            e = sb.pop_front();
            checks++;
            if ({lsu.done, lsu.error, lsu.loadData} !== {1'b1, e.err, e.ld} || lat != e.lat || rd != e.rd || wr != e.wr) begin
                fails++; $display("FAIL err_%0d got done=%b err=%b data=%h lat=%0d rd=%0d wr=%0d required err=%b data=%h lat=%0d rd=%0d wr=%0d",
                                  i, lsu.done, lsu.error, lsu.loadData, lat, rd, wr, e.err, e.ld, e.lat, e.rd, e.wr);
            end
        end
        checks++;
        if (mem[0] !== m0 || mem[1] !== m1 || mem[31] !== 32'h5A5A5A5A) begin
            fails++; $display("FAIL err_mem got w0=%h w1=%h w31=%h required %h %h 5a5a5a5a", mem[0], mem[1], mem[31], m0, m1);
        end
        @(negedge clock);
        lsu.valid = 1'b1; lsu.loadReq = 1'b0; lsu.storeReq = 1'b0;
        @(negedge clock);
        lsu.valid = 1'b0;
        checks++;
        if (lsu.busy !== 1'b0 || lsu.done !== 1'b0) begin
            fails++; $display("FAIL ignored_req got busy=%b done=%b required 0 0", lsu.busy, lsu.done);
        end
    endtask

    task automatic test_reset_mid;
        poke(0, 32'h12345678);
        issue(1'b0, 1'b1, 3'b001, 32'h00, 32'h00005555);
        @(negedge clock);
        checks++;
        if (lsu.memWrite !== 1'b1) begin
            fails++; $display("FAIL reset_mid_write got memWrite=%b required 1", lsu.memWrite);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        last_ld = 32'h0;
        checks++;
        if (mem[0] !== 32'h12345678) begin
            fails++; $display("FAIL reset_mid_mem got %h required 12345678", mem[0]);
        end
        checks++;
        if ({lsu.busy, lsu.done, lsu.error, lsu.memRead, lsu.memWrite} !== 5'b0 || lsu.loadData !== 32'h0 || lsu.memAddress !== 32'h0) begin
            fails++; $display("FAIL reset_mid_outputs got flags=%b data=%h addr=%h required 0",
                              {lsu.busy, lsu.done, lsu.error, lsu.memRead, lsu.memWrite}, lsu.loadData, lsu.memAddress);
        end
        @(negedge clock);
        reset = 1'b1;
        lsu.valid = 1'b1; lsu.loadReq = 1'b1; lsu.storeReq = 1'b0; lsu.funct3 = 3'b010; lsu.address = 32'h10;
        @(negedge clock);
        reset = 1'b0; lsu.valid = 1'b0;
        @(negedge clock);
        checks++;
        if (lsu.busy !== 1'b0 || lsu.loadData !== 32'h0) begin
            fails++; $display("FAIL reset_req_discard got busy=%b data=%h required 0 0", lsu.busy, lsu.loadData);
        end
    endtask

    task automatic test_back_to_back;
        int cnt, rd, wr, n; exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) sb.push_back('{err: 1'b0, ld: 32'hDEADBEEF, lat: 2, rd: 1, wr: 0});
            else        sb.push_back('{err: 1'b0, ld: 32'hDEADBEEF, lat: 3, rd: 1, wr: 1});
            @(negedge clock);
            lsu.valid = 1'b1; lsu.loadReq = (k == 0); lsu.storeReq = (k == 1);
            lsu.funct3 = (k == 0) ? 3'b010 : 3'b001; lsu.address = (k == 0) ? 32'h10 : 32'h12;
            lsu.storeData = 32'h0000CAFE;
            @(negedge clock);
            cnt = 0; rd = 0; wr = 0; n = 0;
            while (lsu.busy && n < 10) begin
                cnt++;
                rd += int'(lsu.memRead);
                wr += int'(lsu.memWrite);
                if (lsu.done) lsu.valid = 1'b0;
                @(negedge clock);
                n++;
            end
            lsu.valid = 1'b0;
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (cnt != e.lat || rd != e.rd || wr != e.wr || lsu.busy !== 1'b0 || lsu.loadData !== e.ld) begin
                fails++; $display("FAIL b2b_%0d got busy_cycles=%0d rd=%0d wr=%0d busy_after=%b data=%h required %0d %0d %0d 0 %h",
                                  k, cnt, rd, wr, lsu.busy, lsu.loadData, e.lat, e.rd, e.wr, e.ld);
            end
        end
        checks++;
        if (mem[4] !== 32'hCAFEBEEF) begin
            fails++; $display("FAIL b2b_mem got %h required cafebeef", mem[4]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        lsu.valid = 1'b0; lsu.loadReq = 1'b0; lsu.storeReq = 1'b0;
        lsu.funct3 = 3'b000; lsu.address = 32'h0; lsu.storeData = 32'h0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        test_reset;
        test_load;
        test_store;
        test_errors;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
